// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - 4-to-16 one-hot pulse decoder with handshake, pulse and gap timing
// Optional even-parity check on the input code: DECODER_PARITY_EN
module onehot_pulse_decoder #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [3:0]  binary_in,
    input  logic        in_valid,
`ifdef DECODER_PARITY_EN
    input  logic        binary_par,
    output logic        par_err,
`endif
    output logic        in_ready,
    output logic [15:0] decoder_out,
    output logic        out_active,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] dec_q, dec_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        active_q, active_d;
    logic        accept;
    logic        par_bad;
    logic        accept_ok;

    assign in_ready  = (state_q == S_IDLE) && enable && reset_n;
    assign accept    = in_valid && in_ready;
    assign accept_ok = accept && !par_bad;

`ifdef DECODER_PARITY_EN
    logic par_err_q, par_err_d;

    assign par_bad   = ^{binary_in, binary_par};
    assign par_err_d = accept && par_bad;
    assign par_err   = par_err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_ok) begin
                    state_d = S_DRIVE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            S_DRIVE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd0) begin
                    if (GAP_LEN == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (!enable || cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output registers are loaded one edge early so they line up with the state they describe.
    always_comb begin
        dec_d  = 16'h0000;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_ok) begin
                    dec_d  = 16'h0001 << binary_in;
                    done_d = (PULSE_LOAD == 8'd0);
                end
            end
            S_DRIVE: begin
                if (enable && cnt_q != 8'd0) begin
                    dec_d  = dec_q;
                    done_d = (cnt_q == 8'd1);
                end
            end
            default: begin
                dec_d  = 16'h0000;
                done_d = 1'b0;
            end
        endcase
        busy_d   = (state_d != S_IDLE);
        active_d = |dec_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dec_q    <= 16'h0000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            dec_q    <= dec_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            active_q <= active_d;
        end
    end

    assign decoder_out = dec_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign out_active  = active_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - directed and random checks of onehot_pulse_decoder against a timing-window model
module tb_onehot_pulse_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        in_valid;
    logic [3:0]  binary_in;
    logic        in_ready_a, in_ready_b;
    logic [15:0] dec_a, dec_b;
    logic        active_a, active_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
`ifdef DECODER_PARITY_EN
    logic        binary_par;
    logic        par_err_a, par_err_b;
    bit          par_flip = 1'b0;
    longint      par_bad_at [2];
    assign binary_par = (^binary_in) ^ par_flip;
`endif

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .binary_in(binary_in), .in_valid(in_valid),
`ifdef DECODER_PARITY_EN
        .binary_par(binary_par), .par_err(par_err_a),
`endif
        .in_ready(in_ready_a), .decoder_out(dec_a), .out_active(active_a), .busy(busy_a), .done(done_a)
    );

    onehot_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .binary_in(binary_in), .in_valid(in_valid),
`ifdef DECODER_PARITY_EN
        .binary_par(binary_par), .par_err(par_err_b),
`endif
        .in_ready(in_ready_b), .decoder_out(dec_b), .out_active(active_b), .busy(busy_b), .done(done_b)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     pl [2] = '{4, 1};
    int     gl [2] = '{1, 0};
    bit     have [2];
    longint acc_n [2];
    logic [3:0] acc_c [2];
    longint ab [2];

    // Cycle t is the interval after edge t; a code accepted at edge N drives cycles N..N+P-1,
    // idles through N+P..N+P+G-1, and anything at or after an abort edge is cut off.
    function automatic bit m_busy(int i, longint t);
        return have[i] && t >= acc_n[i] && t <= acc_n[i] + pl[i] + gl[i] - 1 && t < ab[i];
    endfunction
    function automatic bit m_active(int i, longint t);
        return have[i] && t >= acc_n[i] && t <= acc_n[i] + pl[i] - 1 && t < ab[i];
    endfunction
    function automatic bit m_done(int i, longint t);
        return have[i] && t == acc_n[i] + pl[i] - 1 && t < ab[i];
    endfunction
    function automatic logic [15:0] m_dec(int i, longint t);
        logic [15:0] one;
        one = 16'h0001;
        return m_active(i, t) ? (one << acc_c[i]) : 16'h0000;
    endfunction
    function automatic bit m_ready(int i, longint t);
        return !m_busy(i, t) && enable && reset_n;
    endfunction

    always @(posedge clk) begin : model
        longint prev;
        bit     r [2];
        bit     par_ok;
        prev = cyc;
        for (int i = 0; i < 2; i++) r[i] = m_ready(i, prev);
        par_ok = 1'b1;
`ifdef DECODER_PARITY_EN
        par_ok = !par_flip;
`endif
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                have[i] = 1'b0;
            end else if (!enable && m_busy(i, prev)) begin
                ab[i] = cyc;
            end else if (r[i] && in_valid) begin
                if (par_ok) begin
                    have[i]  = 1'b1;
                    acc_n[i] = cyc;
                    acc_c[i] = binary_in;
                    ab[i]    = 64'h7fff_ffff_ffff_ffff;
                end
`ifdef DECODER_PARITY_EN
                else par_bad_at[i] = cyc;
`endif
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("a_dec",    {16'h0, dec_a},      {16'h0, m_dec(0, cyc)});
        chk("a_active", {31'h0, active_a},   {31'h0, m_active(0, cyc)});
        chk("a_busy",   {31'h0, busy_a},     {31'h0, m_busy(0, cyc)});
        chk("a_done",   {31'h0, done_a},     {31'h0, m_done(0, cyc)});
        chk("a_ready",  {31'h0, in_ready_a}, {31'h0, m_ready(0, cyc)});
        chk("b_dec",    {16'h0, dec_b},      {16'h0, m_dec(1, cyc)});
        chk("b_active", {31'h0, active_b},   {31'h0, m_active(1, cyc)});
        chk("b_busy",   {31'h0, busy_b},     {31'h0, m_busy(1, cyc)});
        chk("b_done",   {31'h0, done_b},     {31'h0, m_done(1, cyc)});
        chk("b_ready",  {31'h0, in_ready_b}, {31'h0, m_ready(1, cyc)});
`ifdef DECODER_PARITY_EN
        chk("a_par_err", {31'h0, par_err_a}, {31'h0, par_bad_at[0] == cyc});
        chk("b_par_err", {31'h0, par_err_b}, {31'h0, par_bad_at[1] == cyc});
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_ready(0, cyc) && m_ready(1, cyc)) && n < 50) begin
            cycle();
            n++;
        end
        chk("idle_timeout", n, (n < 50) ? n : 0);
    endtask

    initial begin
        longint     last;
        int         n;
        logic [15:0] one;
        one = 16'h0001;
        last = 0;
        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0; acc_n[i] = 0; acc_c[i] = 4'd0; ab[i] = 0;
`ifdef DECODER_PARITY_EN
            par_bad_at[i] = -1;
`endif
        end
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; binary_in = 4'd0;
        cycle();
        cycle();
        chk("reset_dec", {16'h0, dec_a}, 32'h0);
        chk("reset_ready", {31'h0, in_ready_a}, 32'h0);
        reset_n = 1'b1;
        cycle();

        // single code 5
        binary_in = 4'd5; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("single_dec", {16'h0, dec_a}, 32'h0020);
            chk("single_done", {31'h0, done_a}, (k == 3) ? 32'h1 : 32'h0);
            cycle();
        end
        chk("single_clear", {16'h0, dec_a}, 32'h0);
        cycle();
        chk("single_ready", {31'h0, in_ready_a}, 32'h1);

        // full sweep, in_valid held high
        wait_idle();
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            binary_in = 4'(c);
            n = 0;
            while (!m_ready(0, cyc) && n < 20) begin
                cycle();
                n++;
            end
            chk("sweep_timeout", n, (n < 20) ? n : 0);
            cycle();
            chk("sweep_dec", {16'h0, dec_a}, {16'h0, one << c});
            if (c > 0) chk("sweep_spacing", 32'(cyc - last), 32'd6);
            last = cyc;
        end
        in_valid = 1'b0;

        // PULSE_LEN=1, GAP_LEN=0 instance: 3 then 9
        wait_idle();
        binary_in = 4'd3; in_valid = 1'b1;
        cycle();
        chk("short_first", {16'h0, dec_b}, 32'h0008);
        binary_in = 4'd9;
        cycle();
        chk("short_idle", {16'h0, dec_b}, 32'h0);
        cycle();
        chk("short_second", {16'h0, dec_b}, 32'h0200);
        in_valid = 1'b0;

        // abort in second drive cycle of code 7
        wait_idle();
        binary_in = 4'd7; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        enable = 1'b0;
        cycle();
        chk("abort_dec", {16'h0, dec_a}, 32'h0);
        repeat (3) begin
            chk("abort_ready", {31'h0, in_ready_a}, 32'h0);
            chk("abort_done", {31'h0, done_a}, 32'h0);
            cycle();
        end
        enable = 1'b1; binary_in = 4'd2; in_valid = 1'b1;
        cycle();
        chk("abort_next", {16'h0, dec_a}, 32'h0004);
        in_valid = 1'b0;

        // reset during the gap of code 15
        wait_idle();
        binary_in = 4'd15; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("in_gap_busy", {31'h0, busy_a}, 32'h1);
        reset_n = 1'b0;
        cycle();
        chk("midreset_busy", {31'h0, busy_a}, 32'h0);
        chk("midreset_dec", {16'h0, dec_a}, 32'h0);
        reset_n = 1'b1; binary_in = 4'd1; in_valid = 1'b1;
        cycle();
        chk("post_reset", {16'h0, dec_a}, 32'h0002);
        in_valid = 1'b0;

`ifdef DECODER_PARITY_EN
        wait_idle();
        binary_in = 4'd3; par_flip = 1'b1; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; par_flip = 1'b0;
        chk("par_err", {31'h0, par_err_a}, 32'h1);
        chk("par_dec", {16'h0, dec_a}, 32'h0);
        cycle();
        in_valid = 1'b1;
        cycle();
        chk("par_ok_dec", {16'h0, dec_a}, 32'h0008);
        in_valid = 1'b0;
`endif

        // random traffic
        for (int it = 0; it < 400; it++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            binary_in = 4'($urandom);
            reset_n   = ($urandom_range(0, 49) != 0);
            cycle();
        end
        reset_n = 1'b1; enable = 1'b1; in_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
